// File: rtl/eth_pkg.sv
// Shared Ethernet frame-scheduler types and constants.
package eth_pkg;

  // State encoding for the frame scheduler FSM
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HDR     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_PAD     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_HDR     = ST_HDR,
    S_PAYLOAD = ST_PAYLOAD,
    S_PAD     = ST_PAD
  } sched_state_t;

  // Ethernet payload limits
  localparam int ETH_MIN_PAYLOAD = 46;
  localparam int ETH_MAX_PAYLOAD = 1500;

  // Default header fields
  localparam logic [47:0] ETH_DEF_DEST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] ETH_DEF_SRC_MAC  = 48'h0200_0000_0001;
  localparam logic [15:0] ETH_DEF_TYPE     = 16'h88B5;

  typedef struct packed {
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
  } eth_hdr_t;

endpackage

// File: rtl/eth_flush_timer.sv
// Idle flush timer: counts while inc, clears on clr, saturates at TIMEOUT.
module eth_flush_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmr;

  // Saturating up-counter; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            tmr <= '0;
    else if (clr)                          tmr <= '0;
    else if (inc && tmr != TW'(TIMEOUT))   tmr <= tmr + TW'(1);
  end

  // Terminal count: launching on this cycle gives exactly TIMEOUT idle cycles
  assign expired = (tmr == TW'(TIMEOUT - 1));

endmodule

// File: rtl/eth_frame_sched.sv
// Frame scheduler: launches header + gated FIFO payload, zero-pads short frames.
module eth_frame_sched
  import eth_pkg::*;
#(
  parameter logic [47:0] DEST_MAC    = ETH_DEF_DEST_MAC,
  parameter logic [47:0] SRC_MAC     = ETH_DEF_SRC_MAC,
  parameter logic [15:0] ETH_TYPE    = ETH_DEF_TYPE,
  parameter int          MAX_PAYLOAD = 1024,
  parameter int          MIN_PAYLOAD = ETH_MIN_PAYLOAD,
  parameter int          TIMEOUT     = 1000,
  parameter int          CNT_W       = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] s_fifo_rd_data_count,
  input  logic [7:0]       s_fifo_tdata,
  input  logic             s_fifo_tvalid,
  output logic             s_fifo_tready,
  output logic             m_eth_hdr_valid,
  input  logic             m_eth_hdr_ready,
  output logic [47:0]      m_eth_dest_mac,
  output logic [47:0]      m_eth_src_mac,
  output logic [15:0]      m_eth_type,
  output logic [7:0]       m_eth_payload_axis_tdata,
  output logic             m_eth_payload_axis_tvalid,
  input  logic             m_eth_payload_axis_tready,
  output logic             m_eth_payload_axis_tlast,
  output logic             m_eth_payload_axis_tuser,
  output logic             busy,
  output logic [15:0]      frame_cnt
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_PAYLOAD);
  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_PAYLOAD);
  localparam eth_hdr_t         HDR     = '{dest_mac: DEST_MAC, src_mac: SRC_MAC, eth_type: ETH_TYPE};

  sched_state_t     state;
  logic [CNT_W-1:0] len, byte_cnt;
  logic             has_data, launch_full, launch_to, launch;
  logic             tmr_clr, tmr_inc, tmr_expired;
  logic             last_data, last_pad, long_frame, beat;

  assign has_data    = (s_fifo_rd_data_count != '0);
  assign launch_full = enable && (s_fifo_rd_data_count >= MAX_LEN);
  assign launch_to   = enable && has_data && tmr_expired;
  assign launch      = (state == S_IDLE) && (launch_full || launch_to);

  // Timer only runs while idle with data waiting; any frame activity resets it
  assign tmr_inc = (state == S_IDLE) && enable && has_data;
  assign tmr_clr = (state != S_IDLE) || !enable || !has_data || launch;

  eth_flush_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expired (tmr_expired)
  );

  assign last_data  = (byte_cnt == len - CNT_W'(1));
  assign last_pad   = (byte_cnt == MIN_LEN - CNT_W'(1));
  assign long_frame = (len >= MIN_LEN);
  assign beat       = m_eth_payload_axis_tvalid && m_eth_payload_axis_tready;

  // Payload mux: FIFO pass-through in PAYLOAD, constant zeros in PAD
  always_comb begin
    m_eth_payload_axis_tdata  = 8'h00;
    m_eth_payload_axis_tvalid = 1'b0;
    m_eth_payload_axis_tlast  = 1'b0;
    s_fifo_tready             = 1'b0;
    unique case (state)
      S_PAYLOAD: begin
        m_eth_payload_axis_tdata  = s_fifo_tdata;
        m_eth_payload_axis_tvalid = s_fifo_tvalid;
        m_eth_payload_axis_tlast  = last_data && long_frame;
        s_fifo_tready             = m_eth_payload_axis_tready;
      end
      S_PAD: begin
        m_eth_payload_axis_tvalid = 1'b1;
        m_eth_payload_axis_tlast  = last_pad;
      end
      default: ;
    endcase
  end

  // Frame FSM: launch decision, header handshake, byte counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      m_eth_hdr_valid <= 1'b0;
      len             <= '0;
      byte_cnt        <= '0;
      frame_cnt       <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (launch) begin
          // count below MAX_LEN whenever only the timeout fires, so no clamp needed there
          len             <= launch_full ? MAX_LEN : s_fifo_rd_data_count;
          byte_cnt        <= '0;
          m_eth_hdr_valid <= 1'b1;
          state           <= S_HDR;
        end
        S_HDR: if (m_eth_hdr_ready) begin
          m_eth_hdr_valid <= 1'b0;
          state           <= S_PAYLOAD;
        end
        S_PAYLOAD: if (beat) begin
          if (last_data && long_frame) begin
            byte_cnt  <= '0;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= S_IDLE;
          end else begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            if (last_data) state <= S_PAD;
          end
        end
        S_PAD: if (beat) begin
          if (last_pad) begin
            byte_cnt  <= '0;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= S_IDLE;
          end else begin
            byte_cnt <= byte_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy                     = (state != S_IDLE);
  assign m_eth_dest_mac           = HDR.dest_mac;
  assign m_eth_src_mac            = HDR.src_mac;
  assign m_eth_type               = HDR.eth_type;
  assign m_eth_payload_axis_tuser = 1'b0;

endmodule

// File: doc/eth_frame_sched.md
Name: eth_frame_sched

Overview:
- Frame scheduler between the eth_clk-side read port of the CDC AXIS byte FIFO and the Ethernet frame transmit interface (header + payload stream).
- Watches FIFO read occupancy and decides when to launch a frame:
  - full-size frame when enough bytes are queued;
  - short frame on idle timeout.
- For each frame it issues the Ethernet header, then gates exactly the chosen number of bytes out of the FIFO.
- Pads short frames with zeros up to the Ethernet minimum payload.

Parameters:
- DEST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC placed in every header
- SRC_MAC, 48'h0200_0000_0001, source MAC placed in every header
- ETH_TYPE, 16'h88B5, EtherType placed in every header
- MAX_PAYLOAD, 1024, full-frame payload bytes; range 46..1500
- MIN_PAYLOAD, 46, minimum payload; shorter frames are zero-padded
- TIMEOUT, 1000, idle cycles before a partial frame is flushed; ≥1
- CNT_W, 11, width of FIFO occupancy count

Ports:
- clk  in  1  eth_clk domain clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  launch permit; sampled only in IDLE
- s_fifo_rd_data_count  in  CNT_W  FIFO read-side occupancy
- s_fifo_tdata  in  8  FIFO output byte
- s_fifo_tvalid  in  1  FIFO output valid
- s_fifo_tready  out  1  FIFO pop
- m_eth_hdr_valid  out  1  header valid
- m_eth_hdr_ready  in  1  header accept
- m_eth_dest_mac  out  48  = DEST_MAC (constant)
- m_eth_src_mac  out  48  = SRC_MAC (constant)
- m_eth_type  out  16  = ETH_TYPE (constant)
- m_eth_payload_axis_tdata  out  8  payload byte
- m_eth_payload_axis_tvalid  out  1  payload valid
- m_eth_payload_axis_tready  in  1  payload accept
- m_eth_payload_axis_tlast  out  1  last payload byte
- m_eth_payload_axis_tuser  out  1  always 0
- busy  out  1  high when not in IDLE
- frame_cnt  out  16  frames completed; wraps at 16'hFFFF→0

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; idle timer=0; byte_cnt=0; frame_cnt=0.
  - Low on reset: hdr_valid, payload tvalid, tlast, s_fifo_tready, busy.
- States: IDLE, HDR, PAYLOAD, PAD.
- IDLE:
  - s_fifo_tready=0.
  - Timer counts up while enable && count>0; clears when count==0 or enable==0.
  - Launch when enable && count≥MAX_PAYLOAD: len=MAX_PAYLOAD. This takes priority over timeout in the same cycle.
  - Otherwise launch when enable && count>0 && timer==TIMEOUT-1: len=count.
  - On launch: latch len, clear timer, assert hdr_valid next cycle, → HDR. Launch-to-hdr_valid latency is 1 cycle.
- HDR:
  - hdr_valid held until the hdr_valid && hdr_ready cycle; then it drops next cycle and state → PAYLOAD.
  - Payload and header never overlap.
- PAYLOAD:
  - Combinational pass-through: m_tdata=s_tdata; m_tvalid=s_tvalid; s_tready=m_tready.
  - byte_cnt increments on each m_tvalid && m_tready.
  - FIFO stalls (tvalid low) propagate as bubbles; no timeout while in a frame.
  - On the byte where byte_cnt==len-1:
    - len≥MIN_PAYLOAD: tlast=1; after the handshake → IDLE and frame_cnt+1.
    - len<MIN_PAYLOAD: tlast=0; after the handshake → PAD.
- PAD:
  - s_tready=0; m_tdata=8'h00; m_tvalid=1.
  - Continue until byte_cnt==MIN_PAYLOAD-1; tlast=1 on that byte.
  - After the handshake → IDLE and frame_cnt+1.
- AXIS rule: tvalid/tdata/tlast stay stable while tvalid && !tready, both in PAYLOAD (FIFO guarantees this) and in PAD.
- Arithmetic:
  - len and byte_cnt are CNT_W bits.
  - len is always in 1..MAX_PAYLOAD; the latched count is clamped to MAX_PAYLOAD.
  - Timer width is clog2(TIMEOUT+1); it saturates, never wraps.
- enable deasserted mid-frame: the current frame completes normally; no new launch.
- Count changing after latch: ignored; len stays fixed for the frame.
- Reset mid-frame: immediate return to IDLE with all outputs low. The downstream frame is truncated without tlast; the downstream block must also be reset.
- busy = (state != IDLE).

Decomposition:
- Shared package eth_pkg:
  - state encoding localparams (IDLE/HDR/PAYLOAD/PAD);
  - ETH_MIN_PAYLOAD=46 and ETH_MAX_PAYLOAD=1500 constants;
  - default MAC/EtherType constants.
- One natural sub-module, eth_flush_timer: the idle timer with clear, enable and saturating terminal-count output. Everything else stays in the top FSM.

Test Plan:
- Full frame: preload 1024 bytes 0x00..0xFF repeating, enable=1, tready=1.
  - Expect hdr_valid 1 cycle after launch.
  - Expect 1024 payload bytes matching input, tlast only on byte 1023.
  - Expect frame_cnt=1 and 0 bytes left in FIFO.
- Timeout flush: write 100 bytes, no more.
  - Launch occurs exactly TIMEOUT cycles after count first becomes nonzero.
  - Frame has 100 bytes with tlast on byte 99.
- Short pad: write 10 bytes 0xA5, wait for timeout.
  - Payload is 10×0xA5 then 36×0x00; tlast on byte 45; FIFO popped exactly 10.
- Backpressure:
  - Random tready (50%) and hdr_ready delayed 20 cycles over a 1024-byte frame.
  - No payload before the header handshake; data, order and tlast are unchanged.
  - Stability holds under stall, including in PAD.
- Priority and enable:
  - count reaches 1024 on the same cycle the timer expires → len=1024.
  - enable dropped mid-frame → frame completes and no next launch with 2000 bytes queued.
- Reset: assert rst_n=0 at payload byte 500.
  - All outputs low asynchronously; frame_cnt=0; state IDLE; no tlast emitted.
